tex_refill_arbiter: RTL

Shares one external burst-read memory port (OSPI/DRAM controller side) between NUM_REQ texture-cache line-refill interfaces.
- Round-robin arbitration; one refill outstanding at a time.
- Issues a burst of MEM_DATA_W-bit beats, assembles the full line, then returns it with a one-cycle response pulse to the granted cache.
- Sits between the per-CU texture caches' miss ports and the memory controller.

---
 rtl/tex_refill_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tex_refill_arbiter.sv
// Round-robin arbiter sharing one burst-read memory port among NUM_REQ texture-cache
// line-refill ports. Define TEX_REFILL_PERF_EN to add perf_refills/perf_wait_cycles.
module tex_refill_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LINE_BYTES = 64,
  parameter int MEM_DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*32-1:0]       req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [LINE_BYTES*8-1:0]     resp_data,
  output logic                        mem_req_valid,
  output logic [31:0]                 mem_req_addr,
  output logic [7:0]                  mem_req_len,
  input  logic                        mem_req_ready,
  input  logic                        mem_rdata_valid,
  input  logic [MEM_DATA_W-1:0]       mem_rdata,
  input  logic                        mem_rdata_last,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        proto_err
`ifdef TEX_REFILL_PERF_EN
  ,
  output logic [31:0]                 perf_refills,
  output logic [31:0]                 perf_wait_cycles
`endif
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / MEM_DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [31:0]       LINE_MASK = ~(32'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  state_t              state_r, state_n_s;
  logic [ID_W-1:0]     rr_ptr_r, grant_id_r, pick_s;
  logic                any_req_s, grant_go_s, addr_hs_s, beat_acc_s, last_beat_s;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [LINE_W-1:0]   line_r;
  logic [31:0]         addr_r;
  logic [7:0]          len_r;
  logic [NUM_REQ-1:0]  req_ready_r, resp_valid_r;
  logic                mem_req_valid_r, proto_err_r;

  // Round-robin pick: scan downward from the farthest slot so the nearest valid slot at/after rr_ptr wins.
  always_comb begin
    any_req_s = |req_valid;
    pick_s    = rr_ptr_r;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick_s = req_valid[(int'(rr_ptr_r) + i) % NUM_REQ] ?
               ID_W'((int'(rr_ptr_r) + i) % NUM_REQ) : pick_s;
    end
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_n_s   = state_r;
    grant_go_s  = 1'b0;
    addr_hs_s   = 1'b0;
    beat_acc_s  = 1'b0;
    last_beat_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_go_s = 1'b1;
          state_n_s  = ADDR;
        end else begin
          state_n_s  = IDLE;
        end
      end
      ADDR: begin
        if (mem_req_ready) begin
          addr_hs_s = 1'b1;
          state_n_s = DATA;
        end else begin
          state_n_s = ADDR;
        end
      end
      DATA: begin
        if (mem_rdata_valid) begin
          beat_acc_s  = 1'b1;
          last_beat_s = (beat_cnt_r == LAST_BEAT);
          state_n_s   = last_beat_s ? RESP : DATA;
        end else begin
          state_n_s   = DATA;
        end
      end
      RESP:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Grant latch and burst request; address is captured line-aligned at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_r      <= '0;
      addr_r          <= 32'd0;
      len_r           <= 8'd0;
      req_ready_r     <= '0;
      mem_req_valid_r <= 1'b0;
    end else begin
      req_ready_r <= grant_go_s ? id_onehot(pick_s) : '0;
      if (grant_go_s) begin
        grant_id_r      <= pick_s;
        addr_r          <= req_addr[int'(pick_s)*32 +: 32] & LINE_MASK;
        len_r           <= 8'(BEATS - 1);
        mem_req_valid_r <= 1'b1;
      end else if (addr_hs_s) begin
        mem_req_valid_r <= 1'b0;
      end
    end
  end

  // Beat assembly, response pulse and sticky burst-length check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r   <= '0;
      line_r       <= '0;
      resp_valid_r <= '0;
      proto_err_r  <= 1'b0;
    end else begin
      resp_valid_r <= (beat_acc_s && last_beat_s) ? id_onehot(grant_id_r) : '0;
      if (addr_hs_s) begin
        beat_cnt_r <= '0;
      end else if (beat_acc_s) begin
        line_r[int'(beat_cnt_r)*MEM_DATA_W +: MEM_DATA_W] <= mem_rdata;
        beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BEAT_W'(1);
      end
      if (beat_acc_s && (mem_rdata_last != last_beat_s)) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  // The requester just served drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (state_r == RESP) begin
      rr_ptr_r <= (grant_id_r == LAST_ID) ? '0 : grant_id_r + ID_W'(1);
    end
  end

  assign req_ready     = req_ready_r;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = line_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = addr_r;
  assign mem_req_len   = len_r;
  assign busy          = (state_r != IDLE);
  assign grant_id      = grant_id_r;
  assign proto_err     = proto_err_r;

`ifdef TEX_REFILL_PERF_EN
  logic [31:0]        perf_refills_r, perf_wait_r, wait_inc_s;
  logic [NUM_REQ-1:0] granted_mask_s;

  // Waiting requesters plus memory stall cycles in ADDR.
  always_comb begin
    granted_mask_s = (state_r != IDLE) ? id_onehot(grant_id_r) : '0;
    wait_inc_s     = {31'd0, |(req_valid & ~granted_mask_s)} +
                     {31'd0, (state_r == ADDR) && !mem_req_ready};
  end

  // Free-running wrapping perf counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_refills_r <= 32'd0;
      perf_wait_r    <= 32'd0;
    end else begin
      perf_refills_r <= perf_refills_r + ((state_r == RESP) ? 32'd1 : 32'd0);
      perf_wait_r    <= perf_wait_r + wait_inc_s;
    end
  end

  assign perf_refills     = perf_refills_r;
  assign perf_wait_cycles = perf_wait_r;
`endif

endmodule
